// File: rtl/riscv_muldiv_pkg.sv
// Shared types and constants for the RV32M/RV64M multiply-divide unit.
package riscv_muldiv_pkg;

  localparam logic [6:0]  FUNCT7_MULDIV = 7'b0000001;
  localparam int unsigned MUL_CNT_W     = 2;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_SIGN,
    ST_DONE
  } md_state_t;

  typedef struct packed {
    logic reg_we;
    logic mem_re;
    logic mem_we;
    logic branch;
    logic alu_src;
    logic muldiv;
  } ctrl_signals_t;

  function automatic logic is_muldiv(input logic [6:0] funct7);
    return funct7 == FUNCT7_MULDIV;
  endfunction

endpackage

// File: rtl/riscv_muldiv_divider.sv
// Iterative radix-2 restoring divider on unsigned magnitudes, one quotient bit per step.
module riscv_muldiv_divider #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            last_o
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN:0]    shift_c;
  logic             ge_c;

  // Dividend bits shift out of the quotient register into the partial remainder.
  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    shift_c = {rem_q, quo_q[XLEN-1]};
    ge_c    = shift_c >= {1'b0, dvs_q};
    if (load_i) begin
      quo_d = dividend_i;
      rem_d = '0;
      dvs_d = divisor_i;
      cnt_d = CNT_W'(XLEN - 1);
    end else if (step_i) begin
      rem_d = ge_c ? XLEN'(shift_c - {1'b0, dvs_q}) : shift_c[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], ge_c};
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign last_o      = (cnt_q == '0);

endmodule

// File: rtl/riscv_muldiv.sv
// RV32M/RV64M multiply-divide unit: pipelined multiplier, iterative divider, control FSM.
module riscv_muldiv
  import riscv_muldiv_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned     PW      = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN - 1){1'b0}}};

  md_state_t            state_q, state_d;
  md_op_t               op_q;
  logic [XLEN-1:0]      op_a_q, op_b_q;
  logic                 neg_a_q, neg_b_q;
  logic [XLEN-1:0]      result_q, result_d;
  logic [MUL_CNT_W-1:0] mul_cnt_q, mul_cnt_d;
  logic                 busy_q, done_q;
  logic                 accept_c, div_load_c, div_step_c, div_last_c;
  logic [XLEN-1:0]      quo_c, rem_c;

  // Accept-time decode: operand magnitudes and the divide fast path.
  logic            div_signed_c, a_neg_c, b_neg_c, div_zero_c, div_ovf_c;
  logic [XLEN-1:0] abs_a_c, abs_b_c, fast_res_c;

  always_comb begin
    div_signed_c = ~funct3_i[0];
    a_neg_c      = div_signed_c & op_a_i[XLEN-1];
    b_neg_c      = div_signed_c & op_b_i[XLEN-1];
    abs_a_c      = a_neg_c ? -op_a_i : op_a_i;
    abs_b_c      = b_neg_c ? -op_b_i : op_b_i;
    div_zero_c   = (op_b_i == '0);
    div_ovf_c    = div_signed_c & (op_a_i == MIN_NEG) & (op_b_i == '1);
    if (div_zero_c) fast_res_c = funct3_i[1] ? op_a_i : '1;
    else            fast_res_c = funct3_i[1] ? '0 : MIN_NEG;
  end

  // Sign/zero-extend to 2*XLEN so the truncated product is exact for every variant.
  logic            a_sx_c, b_sx_c;
  logic [PW-1:0]   prod_c, mul_prod_c;
  logic [XLEN-1:0] mul_res_c;

  always_comb begin
    a_sx_c    = (op_q != MD_MULHU) & op_a_q[XLEN-1];
    b_sx_c    = ((op_q == MD_MUL) | (op_q == MD_MULH)) & op_b_q[XLEN-1];
    prod_c    = {{XLEN{a_sx_c}}, op_a_q} * {{XLEN{b_sx_c}}, op_b_q};
    mul_res_c = (op_q == MD_MUL) ? mul_prod_c[XLEN-1:0] : mul_prod_c[PW-1:XLEN];
  end

  if (MUL_STAGES > 1) begin : g_mul_pipe
    logic [PW-1:0] pipe_q [MUL_STAGES-1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(MUL_STAGES) - 1; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= prod_c;
        for (int i = 1; i < int'(MUL_STAGES) - 1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign mul_prod_c = pipe_q[MUL_STAGES-2];
  end else begin : g_mul_comb
    assign mul_prod_c = prod_c;
  end

  riscv_muldiv_divider #(.XLEN(XLEN)) u_divider (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (div_load_c),
    .step_i     (div_step_c),
    .dividend_i (abs_a_c),
    .divisor_i  (abs_b_c),
    .quotient_o (quo_c),
    .remainder_o(rem_c),
    .last_o     (div_last_c)
  );

  // Quotient negates on differing signs (DIV); remainder follows the dividend (REM).
  logic [XLEN-1:0] sign_res_c;
  always_comb begin
    if (!op_q[1]) sign_res_c = ((op_q == MD_DIV) && (neg_a_q ^ neg_b_q)) ? -quo_c : quo_c;
    else          sign_res_c = ((op_q == MD_REM) && neg_a_q) ? -rem_c : rem_c;
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    mul_cnt_d  = mul_cnt_q;
    accept_c   = 1'b0;
    div_load_c = 1'b0;
    div_step_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          accept_c = 1'b1;
          if (!funct3_i[2]) begin
            state_d   = ST_MUL;
            mul_cnt_d = MUL_CNT_W'(MUL_STAGES - 1);
          end else if (div_zero_c || div_ovf_c) begin
            state_d  = ST_DONE;
            result_d = fast_res_c;
          end else begin
            state_d    = ST_DIV;
            div_load_c = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mul_cnt_q == '0) begin
          state_d  = ST_DONE;
          result_d = mul_res_c;
        end else begin
          mul_cnt_d = mul_cnt_q - MUL_CNT_W'(1);
        end
      end
      ST_DIV: begin
        div_step_c = 1'b1;
        if (div_last_c) state_d = ST_SIGN;
      end
      ST_SIGN: begin
        state_d  = ST_DONE;
        result_d = sign_res_c;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) begin
      state_d    = ST_IDLE;
      result_d   = result_q;
      accept_c   = 1'b0;
      div_load_c = 1'b0;
      div_step_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      mul_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      op_q      <= MD_MUL;
      op_a_q    <= '0;
      op_b_q    <= '0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      mul_cnt_q <= mul_cnt_d;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
      if (accept_c) begin
        op_q    <= md_op_t'(funct3_i);
        op_a_q  <= op_a_i;
        op_b_q  <= op_b_i;
        neg_a_q <= a_neg_c;
        neg_b_q <= b_neg_c;
      end
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Directed bench for riscv_muldiv with a result scoreboard and latency checks.
module tb_riscv_muldiv;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic            flush_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  int              n_cmp = 0;
  int              n_bad = 0;
  int              cyc   = 0;
  logic [XLEN-1:0] sb [$];

  riscv_muldiv #(.XLEN(XLEN), .MUL_STAGES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .funct3_i(funct3_i),
    .op_a_i  (op_a_i),
    .op_b_i  (op_b_i),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .result_o(result_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Called at a negedge inside cycle k; returns at the negedge of cycle k+1.
  task automatic issue(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] exp);
    funct3_i = f3;
    op_a_i   = a;
    op_b_i   = b;
    start_i  = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    start_i = 1'b0;
    cyc     = 1;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    logic [XLEN-1:0] exp;
    while (!done_o && cyc < exp_lat + 40) tick();
    exp = sb.pop_front();
    check({tag, " done"}, 64'(done_o), 64'(1));
    check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, " result"}, 64'(result_o), 64'(exp));
    tick();
    check({tag, " pulse end"}, 64'({done_o, busy_o}), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    start_i  = 1'b0;
    flush_i  = 1'b0;
    funct3_i = 3'b000;
    op_a_i   = '0;
    op_b_i   = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy_o), 64'(0));
    check("reset done", 64'(done_o), 64'(0));
    check("reset result", 64'(result_o), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);       wait_done("mul", 3);
    issue(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000); wait_done("mulh", 3);
    issue(3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000); wait_done("mulhu", 3);
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done("mulhsu", 3);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE); wait_done("mulhu max", 3);
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);        wait_done("div", 34);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);        wait_done("rem", 34);
    issue(3'b101, 32'd100, 32'd7, 32'd14);                     wait_done("divu", 34);
    issue(3'b111, 32'd100, 32'd7, 32'd2);                      wait_done("remu", 34);
    issue(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF);                wait_done("divu by0", 1);
    issue(3'b110, 32'd5, 32'd0, 32'd5);                        wait_done("rem by0", 1);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); wait_done("div ovf", 1);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);        wait_done("rem ovf", 1);

    // A start pulse while busy must not disturb the running divide.
    issue(3'b101, 32'd100, 32'd7, 32'd14);
    tick();
    check("busy during div", 64'(busy_o), 64'(1));
    funct3_i = 3'b000;
    op_a_i   = 32'd3;
    op_b_i   = 32'd3;
    start_i  = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done("start ignored", 34);

    // Flush beats a simultaneous start in IDLE.
    funct3_i = 3'b000;
    start_i  = 1'b1;
    flush_i  = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    flush_i = 1'b0;
    check("flush vs start busy", 64'(busy_o), 64'(0));
    @(negedge clk);
    check("flush vs start done", 64'(done_o), 64'(0));

    // Flush at k+10 of a divide, then a multiply accepted at k+11.
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    while (cyc < 10) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    void'(sb.pop_front());
    check("flush busy", 64'(busy_o), 64'(0));
    check("flush done", 64'(done_o), 64'(0));
    check("flush result held", 64'(result_o), 64'(14));
    issue(3'b000, 32'd6, 32'd7, 32'd42);
    wait_done("mul after flush", 3);

    // Asynchronous reset in the middle of a divide.
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    while (cyc < 5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async rst busy", 64'(busy_o), 64'(0));
    check("async rst done", 64'(done_o), 64'(0));
    check("async rst result", 64'(result_o), 64'(0));
    void'(sb.pop_front());
    @(negedge clk);
    check("rst held done", 64'(done_o), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    issue(3'b101, 32'd9, 32'd3, 32'd3);
    wait_done("divu after reset", 34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_muldiv.md
# riscv_muldiv

Parametrised RV32M/RV64M multiply-divide unit that executes the eight `OP_OP`/funct7=`0000001` instructions beside the single-cycle ALU in EX. Multiplies use a fixed-latency pipelined multiplier. Divides and remainders use an iterative radix-2 restoring divider with a one-cycle fast path for divide-by-zero and signed overflow. The EX stage stalls on `busy_o` and takes `result_o` when `done_o` pulses.

## Interface
- `XLEN`, 32: operand/result width; 32 or 64.
- `MUL_STAGES`, 2: multiplier latency in cycles, 1..4.
- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: reset; one clock, asynchronous, active-low.
- `start_i` in 1: request; accepted only in IDLE.
- `funct3_i` in 3: operation, sampled with `start_i`.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `op_a_i` in XLEN: rs1 value, sampled with `start_i`.
- `op_b_i` in XLEN: rs2 value, sampled with `start_i`.
- `flush_i` in 1: synchronous abort of any in-flight operation.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse; `result_o` valid in the same cycle.
- `result_o` out XLEN: registered result; held until the next `done_o`.

## Operation
- States: IDLE, MUL, DIV, SIGN, DONE.
- IDLE, `start_i`=1, `flush_i`=0: latch operands and funct3, then select the next state:
  - funct3[2]=0 → MUL.
  - Divide by zero or signed overflow → DONE (fast path).
  - Otherwise → DIV.
- MUL:
  - Form a 2·XLEN product from sign/zero-extended operands (XLEN+1 bits each).
  - MUL returns bits [XLEN-1:0]. MULH, MULHSU and MULHU return bits [2·XLEN-1:XLEN].
  - A down-counter loaded with MUL_STAGES-1 moves the state to DONE at zero.
- DIV:
  - Signed ops first take magnitudes of both operands.
  - One quotient bit per cycle, MSB first. The XLEN+1-bit partial remainder subtracts the divisor whenever no borrow results.
  - Stays in DIV for exactly XLEN cycles, then moves to SIGN.
- SIGN:
  - Quotient is negated when the operand signs differ, for DIV only.
  - Remainder takes the dividend's sign, for REM only.
  - Unsigned ops pass through unchanged.
  - Writes `result_o`, then moves to DONE.
- Fast-path results:
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → `op_a`.
  - Signed overflow (DIV of −2^(XLEN−1) by −1): DIV → −2^(XLEN−1); REM → 0.
- DONE: `done_o`=1 for exactly one cycle, then IDLE. `result_o` is written on the edge entering DONE.
- `start_i` while `busy_o`=1: ignored, no side effects.
- `flush_i`=1 in any state: next state is IDLE, no `done_o`, `result_o` unchanged. Flush wins over a simultaneous `start_i`.
- Flush in the DONE cycle: `done_o` still pulses that cycle, since it is registered.

## Timing
- Cycle k is the cycle with `start_i`=1 in IDLE. `done_o` pulses in:
  - Multiply: cycle k+MUL_STAGES+1.
  - Normal divide/remainder: cycle k+XLEN+2.
  - Fast path: cycle k+1.
- Back-to-back: the earliest next accept is cycle done+1. `busy_o` drops in the DONE cycle's successor.
- Reset values: state IDLE, `busy_o`=0, `done_o`=0, `result_o`=0, counters and partial remainder 0.
- Reset assertion mid-operation: immediate return to reset values; no `done_o`.
- Throughput: one operation in flight; no internal queueing.

## Structure
- Shared package additions:
  - `md_op_t`: enum over the eight funct3 encodings.
  - `FUNCT7_MULDIV` = 7'b0000001.
  - `md_state_t`: state enum.
  - `ctrl_signals_t` gains `muldiv` (1 bit).
- Sub-module `riscv_muldiv_divider`:
  - Holds the iterative quotient/remainder datapath and the XLEN-cycle counter.
  - Interface: `load`, `step`, `quotient`, `remainder`.
  - Control FSM, multiplier pipeline and sign fix-up stay in the top level.

## Test plan
- XLEN=32, MUL_STAGES=2; MUL 7 × 0xFFFFFFFD → `result_o`=0xFFFFFFEB, `done_o` at k+3.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU same operands → 0x40000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide of −7 by 2:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD, `done_o` at k+34.
  - REM of the same operands → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14, REMU → 2.
- Fast path, each with `done_o` at k+1:
  - DIVU 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- `start_i` pulsed during busy → ignored. `flush_i` at k+10 of a DIV → no `done_o`, IDLE at k+11, `result_o` unchanged. A new MUL started at k+11 completes at k+14.
- `rst_n` low at k+5 of a DIV → all outputs 0 asynchronously, no `done_o`. After release, DIVU 9 / 3 → 3 at k'+34.
